// File: rtl/data_memory_mmio.sv
// Data memory with combinational-read word RAM plus a small MMIO block (LEDs, switches, timer).
// Optional cycle counter / compare timer is built only when MMIO_TIMER_EN is defined.
module data_memory_mmio #(
  parameter int WORD_ADDR_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic        memory_write_enable,
  output logic [31:0] memory_read_value,
  input  logic [17:0] SW,
  output logic [17:0] LEDR,
  output logic        alignment_error,
  output logic        timer_irq
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  logic                      is_mmio;
  logic                      addr_aligned;
  logic                      ram_wr;
  logic                      mmio_wr;
  logic [7:0]                mmio_off;
  logic [WORD_ADDR_BITS-1:0] ram_idx;
  logic [31:0]               mmio_rdata;
  logic                      unused_bits;

  assign is_mmio      = (memory_address[31:28] == 4'hF);
  assign addr_aligned = (memory_address[1:0] == 2'b00);
  assign ram_wr       = memory_write_enable && addr_aligned && !is_mmio;
  assign mmio_wr      = memory_write_enable && addr_aligned && is_mmio;
  // Byte lane bits are dropped so sub-word reads return the containing word.
  assign mmio_off     = {memory_address[7:2], 2'b00};
  assign ram_idx      = memory_address[WORD_ADDR_BITS+1:2];
  assign unused_bits  = ^{memory_address, memory_write_value};

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram_q [DEPTH];

  always_ff @(posedge clock) begin
    if (ram_wr) begin
      ram_q[ram_idx] <= memory_write_value;
    end
  end

  // ---------------------------------------------------------------- LED register
  logic [17:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (mmio_wr && (mmio_off == OFF_LED)) begin
      led_d = memory_write_value[17:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign LEDR = led_q;

  // ---------------------------------------------------------------- switch synchronizer
  logic [17:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------- alignment error
  logic align_err_q, align_err_d;

  always_comb begin
    align_err_d = align_err_q;
    if (memory_write_enable && !addr_aligned) begin
      align_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign alignment_error = align_err_q;

`ifdef MMIO_TIMER_EN
  // ---------------------------------------------------------------- timer
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic        timer_match;
  logic        status_clear;

  assign timer_match  = (cnt_q == cmp_q) && (cmp_q != 32'd0);
  assign status_clear = mmio_wr && (mmio_off == OFF_STATUS);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    cmp_d = cmp_q;
    if (mmio_wr && (mmio_off == OFF_CMP)) begin
      cmp_d = memory_write_value;
    end
    // A match in the same cycle as a clear keeps the flag set.
    flag_d = flag_q;
    if (timer_match) begin
      flag_d = 1'b1;
    end else if (status_clear) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      cmp_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign timer_irq = flag_q;
`else
  assign timer_irq = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  always_comb begin
    mmio_rdata = 32'd0;
    case (mmio_off)
      OFF_LED:    mmio_rdata = {14'd0, led_q};
      OFF_SW:     mmio_rdata = {14'd0, sw_sync_q};
`ifdef MMIO_TIMER_EN
      OFF_CYCLES: mmio_rdata = cnt_q;
      OFF_CMP:    mmio_rdata = cmp_q;
      OFF_STATUS: mmio_rdata = {31'd0, flag_q};
`else
      OFF_CYCLES: mmio_rdata = 32'd0;
      OFF_CMP:    mmio_rdata = 32'd0;
      OFF_STATUS: mmio_rdata = 32'd0;
`endif
      default:    mmio_rdata = 32'd0;
    endcase
  end

  assign memory_read_value = is_mmio ? mmio_rdata : ram_q[ram_idx];

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed self-checking bench for data_memory_mmio: RAM, aliasing, LEDs, switches,
// alignment error and (when MMIO_TIMER_EN is defined) the cycle counter / compare timer.
module tb_data_memory_mmio;

  logic        clock;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic        memory_write_enable;
  logic [31:0] memory_read_value;
  logic [17:0] SW;
  logic [17:0] LEDR;
  logic        alignment_error;
  logic        timer_irq;

  int tests_run;
  int tests_failed;

  data_memory_mmio #(.WORD_ADDR_BITS(8)) dut (
    .clock               (clock),
    .reset               (reset),
    .memory_address      (memory_address),
    .memory_write_value  (memory_write_value),
    .memory_write_enable (memory_write_enable),
    .memory_read_value   (memory_read_value),
    .SW                  (SW),
    .LEDR                (LEDR),
    .alignment_error     (alignment_error),
    .timer_irq           (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    memory_address      = a;
    memory_write_value  = d;
    memory_write_enable = 1'b1;
    @(posedge clock);
    #1;
    memory_write_enable = 1'b0;
    $display("[TB] write addr=%08h data=%08h", a, d);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (LEDR !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_ledr got=%05h exp=00000", LEDR);
    end
    tests_run++;
    if (alignment_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_align got=%b exp=0", alignment_error);
    end
    tests_run++;
    if (timer_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq got=%b exp=0", timer_irq);
    end
    memory_address = 32'hF000_0004;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_sw_read got=%08h exp=00000000", memory_read_value);
    end
    @(negedge clock);
    reset = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_ram();
    do_write(32'h0000_0040, 32'h1234_5678);
    memory_address = 32'h0000_0040;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ram_read got=%08h exp=12345678", memory_read_value);
    end
    memory_address = 32'h0000_0440;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ram_alias got=%08h exp=12345678", memory_read_value);
    end
    do_write(32'h0000_0100, 32'hCAFE_F00D);
    memory_address = 32'h0000_0103;
    #1;
    tests_run++;
    if (memory_read_value !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL ram_byte_offset_read got=%08h exp=cafef00d", memory_read_value);
    end
    memory_address = 32'h0000_0040;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ram_no_clobber got=%08h exp=12345678", memory_read_value);
    end
    // Same-cycle read/write of one word: old value before the edge, new after.
    @(negedge clock);
    memory_address      = 32'h0000_0040;
    memory_write_value  = 32'h1111_1111;
    memory_write_enable = 1'b1;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL ram_read_old got=%08h exp=12345678", memory_read_value);
    end
    @(posedge clock);
    #1;
    memory_write_enable = 1'b0;
    $display("[TB] write addr=00000040 data=11111111 (read-during-write)");
    tests_run++;
    if (memory_read_value !== 32'h1111_1111) begin
      tests_failed++;
      $display("FAIL ram_read_new got=%08h exp=11111111", memory_read_value);
    end
  endtask

  task automatic test_led();
    do_write(32'hF000_0000, 32'hFFFF_FFFF);
    tests_run++;
    if (LEDR !== 18'h3FFFF) begin
      tests_failed++;
      $display("FAIL led_write got=%05h exp=3ffff", LEDR);
    end
    memory_address = 32'hF000_0000;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h0003_FFFF) begin
      tests_failed++;
      $display("FAIL led_readback got=%08h exp=0003ffff", memory_read_value);
    end
    do_write(32'hF000_0020, 32'h0000_0000);
    memory_address = 32'hF000_0020;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0 || LEDR !== 18'h3FFFF) begin
      tests_failed++;
      $display("FAIL unmapped_access got=%08h led=%05h exp=00000000 led=3ffff",
               memory_read_value, LEDR);
    end
    do_write(32'hF000_0000, 32'h0003_FFFF);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (LEDR !== 18'd0) begin
      tests_failed++;
      $display("FAIL led_async_reset got=%05h exp=00000", LEDR);
    end
    // Write attempted while reset is held must not land.
    memory_address      = 32'hF000_0000;
    memory_write_value  = 32'h0000_0155;
    memory_write_enable = 1'b1;
    @(posedge clock);
    #1;
    memory_write_enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++;
    if (LEDR !== 18'd0) begin
      tests_failed++;
      $display("FAIL led_write_in_reset got=%05h exp=00000", LEDR);
    end
  endtask

  task automatic test_switches();
    @(posedge clock);
    #1;
    SW = 18'h2A5A5;
    memory_address = 32'hF000_0004;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL sw_edge0 got=%08h exp=00000000", memory_read_value);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL sw_edge1_too_early got=%08h exp=00000000", memory_read_value);
    end
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (memory_read_value !== 32'h0002_A5A5) begin
      tests_failed++;
      $display("FAIL sw_edge3 got=%08h exp=0002a5a5", memory_read_value);
    end
    do_write(32'hF000_0004, 32'h0000_0000);
    memory_address = 32'hF000_0004;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h0002_A5A5) begin
      tests_failed++;
      $display("FAIL sw_readonly got=%08h exp=0002a5a5", memory_read_value);
    end
  endtask

  task automatic test_alignment();
    do_write(32'hF000_0000, 32'h0000_0ABC);
    do_write(32'h0000_0042, 32'hDEAD_BEEF);
    memory_address = 32'h0000_0040;
    #1;
    tests_run++;
    if (memory_read_value !== 32'h1111_1111) begin
      tests_failed++;
      $display("FAIL misaligned_ram_suppressed got=%08h exp=11111111", memory_read_value);
    end
    tests_run++;
    if (alignment_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL align_set got=%b exp=1", alignment_error);
    end
    do_write(32'hF000_0001, 32'h0000_0000);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (LEDR !== 18'h00ABC || alignment_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_mmio_sticky led=%05h err=%b exp led=00abc err=1",
               LEDR, alignment_error);
    end
    do_reset();
    #1;
    tests_run++;
    if (alignment_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL align_clear_on_reset got=%b exp=0", alignment_error);
    end
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    logic [31:0] c1;
    logic [31:0] target;
    bit          seen;
    do_reset();
    do_write(32'hF000_000C, 32'd20);
    memory_address = 32'hF000_000C;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd20) begin
      tests_failed++;
      $display("FAIL cmp_readback got=%08h exp=00000014", memory_read_value);
    end
    memory_address = 32'hF000_0008;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock);
      #1;
      if (timer_irq === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || memory_read_value !== 32'd21) begin
      tests_failed++;
      $display("FAIL timer_rise seen=%b count=%0d exp seen=1 count=21", seen, memory_read_value);
    end
    do_write(32'hF000_0010, 32'h0000_0000);
    tests_run++;
    if (timer_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL timer_clear got=%b exp=0", timer_irq);
    end
    memory_address = 32'hF000_0008;
    #1;
    c1 = memory_read_value;
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (memory_read_value !== c1 + 32'd5) begin
      tests_failed++;
      $display("FAIL counter_step got=%0d exp=%0d", memory_read_value, c1 + 32'd5);
    end
    target = memory_read_value + 32'd8;
    do_write(32'hF000_000C, target);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clock);
      #1;
      memory_address = 32'hF000_0008;
      #1;
      if (memory_read_value === target) begin
        seen = 1'b1;
        memory_address      = 32'hF000_0010;
        memory_write_value  = 32'd0;
        memory_write_enable = 1'b1;
        @(posedge clock);
        #1;
        memory_write_enable = 1'b0;
        $display("[TB] write addr=f0000010 data=00000000 (coincides with match)");
      end
    end
    tests_run++;
    if (!seen || timer_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL timer_set_wins seen=%b irq=%b exp seen=1 irq=1", seen, timer_irq);
    end
    do_write(32'hF000_0010, 32'h0000_0001);
    tests_run++;
    if (timer_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL timer_clear2 got=%b exp=0", timer_irq);
    end
  endtask
`else
  task automatic test_no_timer();
    bit irq_seen;
    do_write(32'hF000_000C, 32'd5);
    irq_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (timer_irq !== 1'b0) irq_seen = 1'b1;
    end
    tests_run++;
    if (irq_seen) begin
      tests_failed++;
      $display("FAIL no_timer_irq got=1 exp=0");
    end
    memory_address = 32'hF000_0008;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL no_timer_counter got=%08h exp=00000000", memory_read_value);
    end
    memory_address = 32'hF000_000C;
    #1;
    tests_run++;
    if (memory_read_value !== 32'd0) begin
      tests_failed++;
      $display("FAIL no_timer_cmp got=%08h exp=00000000", memory_read_value);
    end
  endtask
`endif

  initial begin
    tests_run           = 0;
    tests_failed        = 0;
    reset               = 1'b0;
    memory_address      = 32'd0;
    memory_write_value  = 32'd0;
    memory_write_enable = 1'b0;
    SW                  = 18'd0;
    test_reset();
    test_ram();
    test_led();
    test_switches();
    test_alignment();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 SHALL have parameter WORD_ADDR_BITS, default 8: RAM depth of 2^WORD_ADDR_BITS 32-bit words.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port memory_address  input  32  byte address from the processor memory stage.
REQ-005 SHALL have port memory_write_value  input  32  store data.
REQ-006 SHALL have port memory_write_enable  input  1  store strobe, sampled on rising clock.
REQ-007 SHALL have port memory_read_value  output  32  load data, combinational from memory_address.
REQ-008 SHALL have port SW  input  18  board switches, asynchronous to clock.
REQ-009 SHALL have port LEDR  output  18  board LEDs.
REQ-010 SHALL have port alignment_error  output  1  sticky misaligned-access flag.
REQ-011 SHALL have port timer_irq  output  1  timer match flag.

Function
REQ-012 SHALL decode memory_address[31:28] == 4'hF as the MMIO region; all other addresses map to RAM.
REQ-013 RAM SHALL index words by memory_address[WORD_ADDR_BITS+1:2]; higher bits ignored, so addresses alias (wrap) modulo RAM size.
REQ-014 RAM read SHALL be combinational, zero-cycle latency; write SHALL occur on the rising edge when memory_write_enable=1.
REQ-015 Read and write of the same word in one cycle SHALL return the old content; the new value SHALL be visible from the next cycle.
REQ-016 MMIO offsets (memory_address[7:0]) SHALL be: 0x00 LED register (R/W, bits 17:0, upper bits read 0); 0x04 switch value (read-only); 0x08 cycle counter (read-only); 0x0C timer compare (R/W); 0x10 timer status (bit 0 = flag; any write clears).
REQ-017 Unmapped MMIO offsets and writes to read-only offsets SHALL be ignored; unmapped reads SHALL return 0.
REQ-018 LEDR SHALL equal the LED register.
REQ-019 SW SHALL pass through a two-flop synchronizer; a switch change SHALL be readable at offset 0x04 no earlier than 2 and no later than 3 clock edges later.
REQ-020 The cycle counter SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-021 The timer flag SHALL set on the edge after counter == compare with compare != 0; it SHALL remain set until cleared by a write to 0x10.
REQ-022 If set and clear occur in the same cycle, set SHALL win.
REQ-023 timer_irq SHALL equal the timer flag.
REQ-024 A write with memory_address[1:0] != 0 SHALL be suppressed (no RAM or MMIO update) and SHALL set alignment_error; reads SHALL ignore address bits [1:0].
REQ-025 alignment_error SHALL clear only on reset.

Reset
REQ-026 On reset=0, the following SHALL be cleared immediately and asynchronously: LED register, synchronizer flops, counter, compare, timer flag and alignment_error.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 A write coinciding with reset assertion SHALL have no effect on MMIO state.

Configuration
REQ-029 Macro MMIO_TIMER_EN SHALL control the timer.
REQ-030 With MMIO_TIMER_EN defined, offsets 0x08/0x0C/0x10 and timer_irq SHALL behave as in REQ-016 to REQ-023.
REQ-031 Without MMIO_TIMER_EN, no counter, compare or flag storage SHALL exist; those offsets SHALL read 0 and ignore writes, and timer_irq SHALL be tied 0.

Verification
REQ-032 Write 0x12345678 to 0x00000040, then read 0x00000040 next cycle -> 0x12345678; read 0x00000440 with WORD_ADDR_BITS=8 -> 0x12345678 (alias).
REQ-033 Write 0x0003FFFF to 0xF0000000 -> LEDR=0x3FFFF next cycle; assert reset=0 mid-cycle -> LEDR=0 immediately.
REQ-034 Set SW=0x2A5A5 -> reading 0xF0000004 returns 0x0002A5A5 within 3 edges and not before 2.
REQ-035 With MMIO_TIMER_EN, after reset write compare=20 -> timer_irq rises after the counter reaches 20; write 0xF0000010 -> timer_irq=0; a clear coinciding with a match -> timer_irq stays 1.
REQ-036 Write 0xDEADBEEF to 0x00000042 -> word at 0x40 unchanged and alignment_error=1 until reset.
REQ-037 Without MMIO_TIMER_EN, read 0xF0000008 -> 0 and timer_irq=0 throughout.
